// File: rtl/fpu_issue_queue.sv
// Request FIFO and issue sequencer feeding a combinational bfloat16 add/mul datapath.
// Ops issue one at a time; each result returns with its tag on a valid/ready channel.
module fpu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_op_i,
    input  logic [15:0]              req_a_i,
    input  logic [15:0]              req_b_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    output logic [15:0]              fpu_add_a_o,
    output logic [15:0]              fpu_add_b_o,
    input  logic [15:0]              fpu_add_res_i,
    output logic [15:0]              fpu_mul_a_o,
    output logic [15:0]              fpu_mul_b_o,
    input  logic [15:0]              fpu_mul_res_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [15:0]              rsp_data_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] a_mem   [DEPTH];
    logic [DATA_W-1:0] b_mem   [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic              op_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_d;
    logic             push, pop, capture;
    logic             op_q;
    logic [TAG_W-1:0] tag_q;

    // A full FIFO refuses pushes even when the FSM pops in the same cycle.
    assign push = req_valid_i & req_ready_o & ~flush_i;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_o != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (count_o != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            pop     = 1'b0;
            capture = 1'b0;
        end
    end

    always_comb begin
        count_d = count_o + CNT_W'(push) - CNT_W'(pop);
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_o <= (state_d == RESP);
        end
    end

    // FIFO storage needs no reset: occupancy and pointers qualify every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            a_mem[wr_ptr_q]   <= req_a_i;
            b_mem[wr_ptr_q]   <= req_b_i;
            tag_mem[wr_ptr_q] <= req_tag_i;
            op_mem[wr_ptr_q]  <= req_op_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_o     <= '0;
            req_ready_o <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_o     <= '0;
            req_ready_o <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_o     <= count_d;
            req_ready_o <= (count_d != CNT_W'(DEPTH));
        end
    end

    // Only the selected unit's operand pair is loaded on issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q        <= 1'b0;
            tag_q       <= '0;
            fpu_add_a_o <= '0;
            fpu_add_b_o <= '0;
            fpu_mul_a_o <= '0;
            fpu_mul_b_o <= '0;
            rsp_data_o  <= '0;
            rsp_tag_o   <= '0;
        end else begin
            if (pop) begin
                op_q  <= op_mem[rd_ptr_q];
                tag_q <= tag_mem[rd_ptr_q];
                if (op_mem[rd_ptr_q]) begin
                    fpu_mul_a_o <= a_mem[rd_ptr_q];
                    fpu_mul_b_o <= b_mem[rd_ptr_q];
                end else begin
                    fpu_add_a_o <= a_mem[rd_ptr_q];
                    fpu_add_b_o <= b_mem[rd_ptr_q];
                end
            end
            if (capture) begin
                rsp_data_o <= op_q ? fpu_mul_res_i : fpu_add_res_i;
                rsp_tag_o  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: bfloat16 FPU model, directed latency/flush/reset cases and
// a randomized run, with responses checked by a scoreboard monitor.
module tb_fpu_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_tag;
    logic [15:0] fpu_add_a, fpu_add_b, fpu_add_res;
    logic [15:0] fpu_mul_a, fpu_mul_b, fpu_mul_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [2:0]  count;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   rsp_seen = 0;
    bit   rand_rdy = 1'b0;

    fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
        .fpu_add_a_o(fpu_add_a), .fpu_add_b_o(fpu_add_b), .fpu_add_res_i(fpu_add_res),
        .fpu_mul_a_o(fpu_mul_a), .fpu_mul_b_o(fpu_mul_b), .fpu_mul_res_i(fpu_mul_res),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag), .count_o(count)
    );

    always #5 clk = ~clk;

    // bfloat16 <-> real for normal values; results truncate toward zero.
    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] b;
        if (x[14:0] == 15'd0) return 0.0;
        b = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return 16'h0000;
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:45]};
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) * bf2r(b));
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    assign fpu_add_res = bf_add(fpu_add_a, fpu_add_b);
    assign fpu_mul_res = bf_mul(fpu_mul_a, fpu_mul_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected results enter at request acceptance, leave at response handshake.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || flush) begin
                sb_q.delete();
            end else begin
                if (rsp_valid && rsp_ready) begin
                    rsp_seen++;
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL rsp_unexpected: got data=%h tag=%h want none", rsp_data, rsp_tag);
                    end else begin
                        e = sb_q.pop_front();
                        if (rsp_data !== e.data || rsp_tag !== e.tag) begin
                            bad++;
                            $display("FAIL rsp_order: got data=%h tag=%h want data=%h tag=%h",
                                     rsp_data, rsp_tag, e.data, e.tag);
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    e.data = req_op ? bf_mul(req_a, req_b) : bf_add(req_a, req_b);
                    e.tag  = req_tag;
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic ready_randomizer();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = 1'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] tag);
        bit acc;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
            if (acc) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (sb_q.size() == 0 && !rsp_valid) return;
            tick();
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    logic [15:0] h_aa, h_ab, h_ma, h_mb, h_rd;
    int          seen0;
    logic        ops[$];

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;
        fork
            monitor();
            ready_randomizer();
        join_none
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'({rsp_tag, rsp_data}), 32'd0);
        check("rst_fpu", {fpu_add_a | fpu_add_b, fpu_mul_a | fpu_mul_b}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single add: latency of two edges from push to valid.
        push_op(1'b0, 16'h3F80, 16'h4000, 4'd3);
        check("add_cnt_after_push", 32'(count), 32'd1);
        check("add_valid_n", 32'(rsp_valid), 32'd0);
        tick();
        check("add_valid_n1", 32'(rsp_valid), 32'd0);
        check("add_issue_a", 32'(fpu_add_a), 32'h3F80);
        check("add_cnt_issued", 32'(count), 32'd0);
        tick();
        check("add_valid_n2", 32'(rsp_valid), 32'd1);
        check("add_result", 32'({rsp_tag, rsp_data}), 32'h3_4040);
        tick();
        check("add_hold", 32'({rsp_valid, rsp_tag, rsp_data}), 32'h1_3_4040);
        rsp_ready = 1'b1;
        wait_drain();

        // Single mul: add operand pair must hold.
        rsp_ready = 1'b0;
        push_op(1'b1, 16'h4000, 16'h4040, 4'd5);
        tick();
        tick();
        check("mul_result", 32'({rsp_valid, rsp_tag, rsp_data}), 32'h1_5_40C0);
        check("mul_add_hold", {fpu_add_a, fpu_add_b}, 32'h3F80_4000);
        check("mul_operands", {fpu_mul_a, fpu_mul_b}, 32'h4000_4040);
        rsp_ready = 1'b1;
        wait_drain();

        // Six ops with consumer stalled: FIFO fills at four.
        rsp_ready = 1'b0;
        seen0 = rsp_seen;
        for (int i = 0; i < 5; i++) push_op(1'(i % 2), rand_bf(), rand_bf(), 4'(i + 8));
        tick();
        tick();
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        push_op(1'b0, rand_bf(), rand_bf(), 4'd13);
        wait_drain();
        check("six_results", 32'(rsp_seen - seen0), 32'd6);

        // Randomized: 27 adds and 20 muls, shuffled, with random consumer stalls.
        for (int i = 0; i < 27; i++) ops.push_back(1'b0);
        for (int i = 0; i < 20; i++) ops.push_back(1'b1);
        ops.shuffle();
        seen0 = rsp_seen;
        rand_rdy = 1'b1;
        foreach (ops[i]) begin
            push_op(ops[i], rand_bf(), rand_bf(), 4'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        check("rand_results", 32'(rsp_seen - seen0), 32'd47);

        // Flush with three queued and one waiting in RESP.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_op(1'b0, rand_bf(), rand_bf(), 4'(i));
        check("pre_flush_count", 32'(count), 32'd3);
        check("pre_flush_valid", 32'(rsp_valid), 32'd1);
        h_aa = fpu_add_a; h_ab = fpu_add_b; h_ma = fpu_mul_a; h_mb = fpu_mul_b; h_rd = rsp_data;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(rsp_valid), 32'd0);
        check("flush_ready", 32'(req_ready), 32'd1);
        check("flush_hold_add", {fpu_add_a, fpu_add_b}, {h_aa, h_ab});
        check("flush_hold_mul", {fpu_mul_a, fpu_mul_b}, {h_ma, h_mb});
        check("flush_hold_data", 32'(rsp_data), 32'(h_rd));
        rsp_ready = 1'b1;
        seen0 = rsp_seen;
        push_op(1'b1, 16'h3FC0, 16'h4000, 4'd7);
        wait_drain();
        check("post_flush_results", 32'(rsp_seen - seen0), 32'd1);

        // Asynchronous reset while an op is in EXEC.
        rsp_ready = 1'b0;
        push_op(1'b1, 16'h4040, 16'h4040, 4'd9);
        push_op(1'b0, 16'h4000, 16'h4000, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count_ready", 32'({req_ready, count}), 32'h8);
        check("arst_rsp", 32'({rsp_valid, rsp_tag, rsp_data}), 32'd0);
        check("arst_fpu", {fpu_add_a | fpu_add_b, fpu_mul_a | fpu_mul_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen0 = rsp_seen;
        push_op(1'b0, 16'h4040, 16'h3F80, 4'd1);
        wait_drain();
        check("post_reset_results", 32'(rsp_seen - seen0), 32'd1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
